// File: rtl/constant_encoder.sv
// Splits a 32-bit constant into the IM/CS immediate chunks that rebuild it.
// Fitting values become one chunk; others a zero-filled 3-chunk shift/OR run.
module constant_encoder #(
  parameter bit ENABLE_MULTI = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [14:0]      IM,
  output logic             CS,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             err,
  output logic [CNT_W-1:0] multi_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT,
    M2,
    M1,
    M0
  } state_t;

  state_t state, stateNxt;

  logic [14:0] imNxt;
  logic        csNxt;
  logic [1:0]  idxNxt;
  logic        lastNxt;
  logic [14:0] midQ, midNxt;
  logic [14:0] lowQ, lowNxt;
  logic        errNxt;
  logic [CNT_W-1:0] cntNxt;

  logic accept;
  logic xfer;
  logic isZf;
  logic isSe;

  assign out_valid = (state != IDLE);
  assign in_ready  = !out_valid || (out_ready && out_last);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;

  assign isZf = (in_data[31:15] == 17'd0);
  assign isSe = &in_data[31:14];

  always_comb begin
    stateNxt = state;
    imNxt    = IM;
    csNxt    = CS;
    idxNxt   = out_idx;
    lastNxt  = out_last;
    midNxt   = midQ;
    lowNxt   = lowQ;
    errNxt   = 1'b0;
    cntNxt   = multi_cnt;

    unique case (state)
      IDLE: ;
      EMIT, M0: begin
        if (xfer) begin
          stateNxt = IDLE;
          imNxt    = 15'd0;
          csNxt    = 1'b0;
          idxNxt   = 2'd0;
          lastNxt  = 1'b0;
        end
      end
      M2: begin
        if (xfer) begin
          stateNxt = M1;
          imNxt    = midQ;
          idxNxt   = 2'd1;
        end
      end
      M1: begin
        if (xfer) begin
          stateNxt = M0;
          imNxt    = lowQ;
          idxNxt   = 2'd0;
          lastNxt  = 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase

    // A new accept overrides the retire above (last-transfer/accept overlap).
    if (accept) begin
      unique case (1'b1)
        isZf, isSe: begin
          stateNxt = EMIT;
          imNxt    = in_data[14:0];
          csNxt    = !isZf;
          idxNxt   = 2'd0;
          lastNxt  = 1'b1;
        end
        default: begin
          if (ENABLE_MULTI) begin
            stateNxt = M2;
            imNxt    = {13'd0, in_data[31:30]};
            csNxt    = 1'b0;
            idxNxt   = 2'd2;
            lastNxt  = 1'b0;
            midNxt   = in_data[29:15];
            lowNxt   = in_data[14:0];
            if (multi_cnt != {CNT_W{1'b1}})
              cntNxt = multi_cnt + CNT_W'(1);
          end else begin
            errNxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      IM        <= 15'd0;
      CS        <= 1'b0;
      out_idx   <= 2'd0;
      out_last  <= 1'b0;
      midQ      <= 15'd0;
      lowQ      <= 15'd0;
      err       <= 1'b0;
      multi_cnt <= '0;
    end else begin
      state     <= stateNxt;
      IM        <= imNxt;
      CS        <= csNxt;
      out_idx   <= idxNxt;
      out_last  <= lastNxt;
      midQ      <= midNxt;
      lowQ      <= lowNxt;
      err       <= errNxt;
      multi_cnt <= cntNxt;
    end
  end

endmodule

// File: tb/tb_constant_encoder.sv
// Directed checks of constant_encoder: single/multi chunking, stalls,
// back-to-back accepts, drop/err mode and mid-sequence reset.
module tb_constant_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inValid;
  logic [31:0] inData;
  logic        inReady;
  logic        outValid;
  logic        outReady;
  logic [14:0] im;
  logic        cs;
  logic [1:0]  outIdx;
  logic        outLast;
  logic        err;
  logic [15:0] multiCnt;

  logic        inValidB;
  logic [31:0] inDataB;
  logic        inReadyB;
  logic        outValidB;
  logic [14:0] imB;
  logic        csB;
  logic [1:0]  outIdxB;
  logic        outLastB;
  logic        errB;
  logic [15:0] multiCntB;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  constant_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_data   (inData),
    .in_ready  (inReady),
    .out_valid (outValid),
    .out_ready (outReady),
    .IM        (im),
    .CS        (cs),
    .out_idx   (outIdx),
    .out_last  (outLast),
    .err       (err),
    .multi_cnt (multiCnt)
  );

  constant_encoder #(.ENABLE_MULTI(1'b0)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValidB),
    .in_data   (inDataB),
    .in_ready  (inReadyB),
    .out_valid (outValidB),
    .out_ready (1'b1),
    .IM        (imB),
    .CS        (csB),
    .out_idx   (outIdxB),
    .out_last  (outLastB),
    .err       (errB),
    .multi_cnt (multiCntB)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkChunk(input string tag, input logic [14:0] eIm,
                          input logic eCs, input logic [1:0] eIdx,
                          input logic eLast);
    chk({tag, ".valid"}, {31'd0, outValid}, 32'd1);
    chk({tag, ".IM"}, {17'd0, im}, {17'd0, eIm});
    chk({tag, ".CS"}, {31'd0, cs}, {31'd0, eCs});
    chk({tag, ".idx"}, {30'd0, outIdx}, {30'd0, eIdx});
    chk({tag, ".last"}, {31'd0, outLast}, {31'd0, eLast});
  endtask

  initial begin
    rst_n    = 1'b0;
    inValid  = 1'b0;
    inData   = 32'd0;
    outReady = 1'b1;
    inValidB = 1'b0;
    inDataB  = 32'd0;
    tick();
    tick();
    chk("rst.valid", {31'd0, outValid}, 32'd0);
    chk("rst.IM", {17'd0, im}, 32'd0);
    chk("rst.CS", {31'd0, cs}, 32'd0);
    chk("rst.last", {31'd0, outLast}, 32'd0);
    chk("rst.err", {31'd0, err}, 32'd0);
    chk("rst.cnt", {16'd0, multiCnt}, 32'd0);
    rst_n = 1'b1;

    // Single zero-filled
    inValid = 1'b1;
    inData  = 32'h0000_1234;
    chk("zf.inReady0", {31'd0, inReady}, 32'd1);
    tick();
    inValid = 1'b0;
    chkChunk("zf1234", 15'h1234, 1'b0, 2'd0, 1'b1);
    chk("zf.inReady1", {31'd0, inReady}, 32'd1);
    tick();
    chk("zf.idle", {31'd0, outValid}, 32'd0);

    // Sign-extended then zero-filled back to back
    inValid = 1'b1;
    inData  = 32'hFFFF_C000;
    tick();
    chkChunk("seC000", 15'h4000, 1'b1, 2'd0, 1'b1);
    inData = 32'h0000_4000;
    tick();
    chkChunk("zf4000", 15'h4000, 1'b0, 2'd0, 1'b1);
    inData = 32'h0000_7FFF;
    tick();
    chkChunk("zf7FFF", 15'h7FFF, 1'b0, 2'd0, 1'b1);
    inData = 32'h0000_0000;
    tick();
    chkChunk("zf0", 15'h0000, 1'b0, 2'd0, 1'b1);
    inValid = 1'b0;
    tick();
    chk("b2b.idle", {31'd0, outValid}, 32'd0);

    // Multi: in_valid held during idx2 must be ignored
    inValid = 1'b1;
    inData  = 32'h1234_5678;
    tick();
    chkChunk("m.idx2", 15'h0000, 1'b0, 2'd2, 1'b0);
    chk("m.inReady2", {31'd0, inReady}, 32'd0);
    chk("m.cnt", {16'd0, multiCnt}, 32'd1);
    tick();
    inValid = 1'b0;
    chkChunk("m.idx1", 15'h2468, 1'b0, 2'd1, 1'b0);
    chk("m.inReady1", {31'd0, inReady}, 32'd0);
    tick();
    chkChunk("m.idx0", 15'h5678, 1'b0, 2'd0, 1'b1);
    tick();
    chk("m.idle", {31'd0, outValid}, 32'd0);
    chk("m.cntHold", {16'd0, multiCnt}, 32'd1);

    // Multi with stalls
    inValid  = 1'b1;
    inData   = 32'hC000_0001;
    tick();
    inValid  = 1'b0;
    outReady = 1'b0;
    chkChunk("st.idx2a", 15'h0003, 1'b0, 2'd2, 1'b0);
    tick();
    chkChunk("st.idx2b", 15'h0003, 1'b0, 2'd2, 1'b0);
    tick();
    chkChunk("st.idx2c", 15'h0003, 1'b0, 2'd2, 1'b0);
    outReady = 1'b1;
    tick();
    chkChunk("st.idx1", 15'h0000, 1'b0, 2'd1, 1'b0);
    tick();
    chkChunk("st.idx0", 15'h0001, 1'b0, 2'd0, 1'b1);
    tick();
    chk("st.idle", {31'd0, outValid}, 32'd0);
    chk("st.cnt", {16'd0, multiCnt}, 32'd2);

    // Back-to-back 5 then all ones
    inValid = 1'b1;
    inData  = 32'h0000_0005;
    tick();
    chkChunk("bb5", 15'h0005, 1'b0, 2'd0, 1'b1);
    inData = 32'hFFFF_FFFF;
    tick();
    chkChunk("bbFFFF", 15'h7FFF, 1'b1, 2'd0, 1'b1);

    // Single last chunk overlapped with a multi accept; bit14=0 forces multi
    inData = 32'hFFFF_8000;
    tick();
    inValid = 1'b0;
    chkChunk("b8.idx2", 15'h0003, 1'b0, 2'd2, 1'b0);
    chk("b8.cnt", {16'd0, multiCnt}, 32'd3);
    tick();
    chkChunk("b8.idx1", 15'h7FFF, 1'b0, 2'd1, 1'b0);
    tick();
    chkChunk("b8.idx0", 15'h0000, 1'b0, 2'd0, 1'b1);
    tick();
    chk("b8.idle", {31'd0, outValid}, 32'd0);

    // Drop mode
    inValidB = 1'b1;
    inDataB  = 32'h8000_0000;
    tick();
    inValidB = 1'b0;
    chk("drop.valid", {31'd0, outValidB}, 32'd0);
    chk("drop.err", {31'd0, errB}, 32'd1);
    chk("drop.cnt", {16'd0, multiCntB}, 32'd0);
    tick();
    chk("drop.errClr", {31'd0, errB}, 32'd0);
    chk("drop.valid2", {31'd0, outValidB}, 32'd0);
    inValidB = 1'b1;
    inDataB  = 32'h0000_1234;
    tick();
    inValidB = 1'b0;
    chk("dropSingle.valid", {31'd0, outValidB}, 32'd1);
    chk("dropSingle.IM", {17'd0, imB}, 32'h1234);
    chk("dropSingle.err", {31'd0, errB}, 32'd0);
    tick();

    // Reset during idx1
    inValid = 1'b1;
    inData  = 32'h1234_5678;
    tick();
    inValid = 1'b0;
    tick();
    chkChunk("rs.idx1", 15'h2468, 1'b0, 2'd1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("rs.valid", {31'd0, outValid}, 32'd0);
    chk("rs.cnt", {16'd0, multiCnt}, 32'd0);
    chk("rs.inReady", {31'd0, inReady}, 32'd1);
    chk("rs.IM", {17'd0, im}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rs.stayIdle", {31'd0, outValid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/constant_encoder.md
Name: constant_encoder

Overview:
- Inverse of the datapath constant unit. The constant unit expands a 15-bit immediate IM with control CS into a 32-bit word: CS=1 sign-extends, CS=0 zero-fills.
- This block takes a 32-bit constant and produces the immediate field(s) that rebuild it.
- A constant that fits one immediate is emitted as a single IM/CS pair.
- Any other constant is emitted as a three-chunk zero-filled sequence for a shift-by-15/OR build sequence.
- Sits between the instruction/constant generator and the instruction-word assembler, with valid/ready on both sides.

Parameters:
- ENABLE_MULTI, 1: 1 = emit non-fitting constants as chunk sequences; 0 = drop them and pulse err.
- CNT_W, 16: width of the saturating multi-chunk statistics counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  constant available
- in_data  input  32  constant to encode
- in_ready  output  1  block accepts in_data this cycle
- out_valid  output  1  IM/CS chunk valid
- out_ready  input  1  downstream consumes chunk
- IM  output  15  immediate field
- CS  output  1  1 = sign-extend, 0 = zero-fill
- out_idx  output  2  chunk index: 0 = least significant/only, 1 = middle, 2 = top
- out_last  output  1  final chunk of this constant
- err  output  1  one-cycle pulse: non-fitting constant dropped (ENABLE_MULTI=0)
- multi_cnt  output  CNT_W  count of constants emitted as chunk sequences, saturating

Behaviour:
- Reset (rst_n low at a clk edge) sets, regardless of state or pending handshake:
  - state IDLE
  - out_valid=0, IM=0, CS=0, out_idx=0, out_last=0
  - err=0, multi_cnt=0
- A reset mid-sequence abandons the remaining chunks.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - in_ready = !out_valid || (out_ready && out_last), combinational. This allows back-to-back constants with no bubble.
  - Chunk transferred when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, IM/CS/out_idx/out_last hold stable.
- Classification of an accepted value v, first match wins:
  - SINGLE_ZF: v[31:15]==0 -> IM=v[14:0], CS=0, out_idx=0, out_last=1.
  - SINGLE_SE: v[31:14] all ones -> IM=v[14:0], CS=1, out_idx=0, out_last=1.
  - MULTI, otherwise, with ENABLE_MULTI=1. Three chunks, all CS=0, in order:
    - idx2: IM={13'b0, v[31:30]}
    - idx1: IM=v[29:15]
    - idx0: IM=v[14:0], out_last=1
  - The consumer rebuilds the constant as ((c2<<15)|c1)<<15|c0.
- With ENABLE_MULTI=0, a MULTI constant is accepted, nothing is emitted, and err=1 for the following cycle.
- Latency: the first chunk is out_valid the cycle after acceptance (registered outputs).
- FSM states:
  - IDLE
  - EMIT (single chunk)
  - M2, M1, M0 (multi chunks)
- Transitions:
  - IDLE -> EMIT or M2 on accept.
  - M2 -> M1 and M1 -> M0 on transfer.
  - EMIT or M0 -> IDLE on transfer without a new accept.
  - EMIT or M0 -> EMIT or M2 directly on transfer with a simultaneous accept. This is the simultaneous last-transfer/accept case; the new constant's first chunk is presented next cycle.
  - in_valid is ignored in M2 and M1 (in_ready=0).
- multi_cnt increments by 1 when M2 is entered. It holds at 2^CNT_W-1 and does not wrap.
- Boundary values:
  - 0x00000000 -> SINGLE_ZF, IM=0.
  - 0x00007FFF -> SINGLE_ZF.
  - 0xFFFFC000 -> SINGLE_SE.
  - 0xFFFFFFFF -> SINGLE_SE, IM=0x7FFF.
  - 0xFFFF8000 -> MULTI, because bit14=0.

Test Plan:
- Reset, then in_data=0x00001234 with out_ready=1 -> next cycle IM=0x1234, CS=0, out_idx=0, out_last=1; in_ready stays 1.
- in_data=0xFFFFC000 -> IM=0x4000, CS=1, out_last=1. in_data=0x00004000 -> IM=0x4000, CS=0.
- in_data=0x12345678 with out_ready=1 -> three consecutive chunks: (idx2, 0x0000), (idx1, 0x2468), (idx0, 0x5678, last), all CS=0; multi_cnt=1; in_ready=0 during idx2 and idx1.
- in_data=0xC0000001 with out_ready toggling 1,0,0,1,1 -> chunk idx2 IM=0x0003 held across stall cycles, then idx1 0x0000, then idx0 0x0001; no chunk duplicated or lost.
- Back-to-back: 0x00000005 then 0xFFFFFFFF presented continuously with out_ready=1 -> outputs IM=0x0005 CS=0, then IM=0x7FFF CS=1 on consecutive cycles.
- ENABLE_MULTI=0 with in_data=0x80000000 -> no out_valid, err=1 for one cycle. Separately, assert rst_n=0 during chunk idx1 of 0x12345678 -> next cycle out_valid=0, multi_cnt=0, state IDLE.
